// File: rtl/sqr_repeat_ctrl.sv
// Repeat-squaring sequencer: looks up a repeat count in the external ROM, then
// issues that many single-squaring requests, one outstanding at a time.
module sqr_repeat_ctrl #(
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] sel,
    input  logic              abort,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [CNT_W-1:0]  rom_dout,
    output logic              sq_en,
    input  logic              sq_ack,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  remaining
);

    // state  | meaning
    // S_IDLE | waiting for start; rom_addr keeps the last accepted sel
    // S_LOAD | ROM data valid for rom_addr; latch the repeat count
    // S_RUN  | one-cycle sq_en request to the squarer
    // S_WAIT | waiting for sq_ack of the outstanding request
    // S_DONE | one-cycle done pulse
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_WAIT,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [CNT_W-1:0]  rem_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rom_addr  <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            rom_addr  <= addr_nxt;
            remaining <= rem_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        addr_nxt  = rom_addr;
        rem_nxt   = remaining;
        case (state)
            S_IDLE: begin
                if (start) begin
                    addr_nxt  = sel;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    rem_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    rem_nxt   = rom_dout;
                    state_nxt = (rom_dout == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // an ack coinciding with the request itself is not ours
                if (abort) begin
                    rem_nxt   = '0;
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort) begin
                    rem_nxt   = '0;
                    state_nxt = S_IDLE;
                end else if (sq_ack) begin
                    if (remaining != '0) begin
                        rem_nxt = remaining - CNT_W'(1);
                    end
                    state_nxt = (remaining <= CNT_W'(1)) ? S_DONE : S_RUN;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign sq_en = (state == S_RUN);
    assign busy  = (state == S_LOAD) || (state == S_RUN) || (state == S_WAIT);
    assign done  = (state == S_DONE);

endmodule

// File: tb/tb_sqr_repeat_ctrl.sv
// Scoreboard bench for sqr_repeat_ctrl: directed runs push expected sq_en/done
// events; a monitor pops and compares them whenever the DUT presents one.
module tb_sqr_repeat_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  sel = 3'd0;
    logic        abort = 1'b0;
    logic [2:0]  rom_addr;
    logic [15:0] rom_dout;
    logic        sq_en;
    logic        sq_ack;
    logic        busy;
    logic        done;
    logic [15:0] remaining;

    logic ack_model = 1'b0;
    logic ack_man   = 1'b0;
    bit   resp_on   = 1'b1;
    bit   rand_dly  = 1'b0;
    bit   chk_spacing = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_sq = -1;
    int sq_count = 0;

    typedef struct {
        bit          is_done;
        logic [15:0] rem;
        logic [2:0]  addr;
    } ev_t;
    ev_t sbq[$];

    assign sq_ack = ack_model | ack_man;

    // Repeat-count ROM contents as seen by the Koblitz datapath
    function automatic logic [15:0] rom_val(input logic [2:0] a);
        case (a)
            3'd1:    rom_val = 16'd1;
            3'd2:    rom_val = 16'd32;
            3'd3:    rom_val = 16'd128;
            3'd4:    rom_val = 16'd40;
            default: rom_val = 16'd0;
        endcase
    endfunction

    assign rom_dout = rom_val(rom_addr);

    sqr_repeat_ctrl #(.ADDR_W(3), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sel       (sel),
        .abort     (abort),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout),
        .sq_en     (sq_en),
        .sq_ack    (sq_ack),
        .busy      (busy),
        .done      (done),
        .remaining (remaining)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sq(input int rem);
        ev_t e;
        e.is_done = 1'b0;
        e.rem     = 16'(rem);
        e.addr    = 3'd0;
        sbq.push_back(e);
    endtask

    task automatic push_run(input logic [2:0] s);
        ev_t e;
        int n;
        n = int'(rom_val(s));
        for (int i = 0; i < n; i++) push_sq(n - i);
        e.is_done = 1'b1;
        e.rem     = 16'd0;
        e.addr    = s;
        sbq.push_back(e);
    endtask

    task automatic start_run(input logic [2:0] s);
        start = 1'b1;
        sel   = s;
        tick();
        start = 1'b0;
    endtask

    // lat counts cycles after the start edge; returns at the negedge of the done cycle
    task automatic wait_done(output int lat, output int busy_cyc);
        bit found;
        found    = 1'b0;
        lat      = 1;
        busy_cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (busy) busy_cyc++;
            if (done) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (!found) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_sq();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sq_en) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk("sq_timeout", 0, 1);
    endtask

    // Squarer model: one ack, 1..5 cycles after the request cycle
    initial begin
        int d;
        forever begin
            @(negedge clk);
            if (sq_en && resp_on) begin
                d = rand_dly ? int'($urandom_range(1, 5)) : 1;
                repeat (d) @(posedge clk);
                #1 ack_model = 1'b1;
                @(posedge clk);
                #1 ack_model = 1'b0;
            end
        end
    end

    // Monitor
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            if (sq_en) begin
                sq_count++;
                if (chk_spacing && last_sq >= 0) chk("sq_spacing", cyc - last_sq, 2);
                last_sq = cyc;
                if (sbq.size() == 0) begin
                    chk("unexpected_sq_en", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("event_kind_sq", int'(e.is_done), 0);
                    chk("sq_remaining", int'(remaining), int'(e.rem));
                end
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("event_kind_done", int'(e.is_done), 1);
                    chk("done_remaining", int'(remaining), 0);
                    chk("done_rom_addr", int'(rom_addr), int'(e.addr));
                end
            end
        end
    end

    initial begin
        int lat, bc, sq0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rom_addr", int'(rom_addr), 0);
        chk("rst_sq_en", int'(sq_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_remaining", int'(remaining), 0);
        rst = 1'b0;
        tick();

        // sel=1, single squaring
        sq0 = sq_count;
        push_run(3'd1);
        start_run(3'd1);
        wait_done(lat, bc);
        chk("sel1_latency", lat, 4);
        chk("sel1_sq_count", sq_count - sq0, 1);
        tick();
        chk("sel1_busy_after", int'(busy), 0);
        chk("sel1_rom_addr_hold", int'(rom_addr), 1);

        // sel=2, immediate acks, 2-cycle spacing
        sq0 = sq_count;
        last_sq = -1;
        chk_spacing = 1'b1;
        push_run(3'd2);
        start_run(3'd2);
        wait_done(lat, bc);
        chk_spacing = 1'b0;
        chk("sel2_latency", lat, 66);
        chk("sel2_sq_count", sq_count - sq0, 32);
        tick();

        // zero-count entries
        sq0 = sq_count;
        push_run(3'd0);
        start_run(3'd0);
        wait_done(lat, bc);
        chk("sel0_latency", lat, 2);
        chk("sel0_busy_cycles", bc, 1);
        tick();
        push_run(3'd6);
        start_run(3'd6);
        wait_done(lat, bc);
        chk("sel6_latency", lat, 2);
        chk("sel6_busy_cycles", bc, 1);
        chk("sel0_6_sq_count", sq_count - sq0, 0);
        tick();
        chk("sel6_busy_after", int'(busy), 0);

        // sel=3, random ack delays, stray start while busy, stray ack in idle
        sq0 = sq_count;
        rand_dly = 1'b1;
        push_run(3'd3);
        start_run(3'd3);
        repeat (20) tick();
        start = 1'b1;
        sel   = 3'd0;
        tick();
        start = 1'b0;
        sel   = 3'd3;
        wait_done(lat, bc);
        rand_dly = 1'b0;
        chk("sel3_sq_count", sq_count - sq0, 128);
        tick();
        ack_man = 1'b1;
        tick();
        ack_man = 1'b0;
        repeat (3) tick();
        chk("stray_ack_busy", int'(busy), 0);
        chk("stray_ack_remaining", int'(remaining), 0);
        chk("sb_empty_sel3", sbq.size(), 0);

        // sel=4, abort coincident with the 11th ack
        resp_on = 1'b0;
        for (int i = 0; i <= 10; i++) push_sq(40 - i);
        start_run(3'd4);
        for (int i = 0; i < 11; i++) begin
            wait_sq();
            tick();
            ack_man = 1'b1;
            if (i == 10) abort = 1'b1;
            tick();
            ack_man = 1'b0;
            abort   = 1'b0;
        end
        chk("abort_busy", int'(busy), 0);
        chk("abort_remaining", int'(remaining), 0);
        chk("abort_done", int'(done), 0);
        repeat (4) tick();
        chk("sb_empty_abort", sbq.size(), 0);
        resp_on = 1'b1;
        push_run(3'd1);
        start_run(3'd1);
        wait_done(lat, bc);
        chk("after_abort_latency", lat, 4);
        tick();

        // sel=2, async reset in WAIT
        resp_on = 1'b0;
        push_sq(32);
        start_run(3'd2);
        wait_sq();
        tick();
        chk("pre_rst_busy", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_rom_addr", int'(rom_addr), 0);
        chk("arst_sq_en", int'(sq_en), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_remaining", int'(remaining), 0);
        chk("sb_empty_rst", sbq.size(), 0);
        #2 rst = 1'b0;
        tick();
        resp_on = 1'b1;
        push_run(3'd1);
        start_run(3'd1);
        wait_done(lat, bc);
        chk("after_rst_latency", lat, 4);
        repeat (3) tick();
        chk("sb_empty_final", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
